// File: rtl/serial_add_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM state
// encoding and the default operand width.
package serial_add_ctrl_pkg;

   // Controller states. The encoding is fixed so that debug tooling can
   // decode the exported state directly.
   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_t;

   localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_add_ctrl_full_add_cell.sv
// One-bit full adder built from two half adders plus an OR of their carries.
// Purely combinational; the controller that sequences it holds all state.

module halfadder (
   input  logic a,
   input  logic b,
   output logic s,
   output logic c
);
   assign s = a ^ b;
   assign c = a & b;
endmodule

module full_add_cell (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);
   logic s0;
   logic c0;
   logic c1;

   // First stage adds the operand bits, second stage folds in the carry.
   halfadder u_ha0 (.a(a),  .b(b),  .s(s0), .c(c0));
   halfadder u_ha1 (.a(s0), .b(ci), .s(s),  .c(c1));

   // At most one of the two stage carries can be set, so OR is exact.
   assign co = c0 | c1;
endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller. Captures two WIDTH-bit operands and a carry-in,
// then feeds one full-adder cell LSB-first for WIDTH cycles, shifting each sum
// bit into the top of the sum register. The finished result is offered until
// the consumer takes it.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. The producer keeps valid and its data stable until that edge;
// ready may be high without valid. in_ready is high only in IDLE, and
// out_valid is high only in DONE, so the two handshakes never overlap.
module serial_add_ctrl
   import serial_add_ctrl_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             busy,
   output state_t           state_dbg
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   state_t           state;
   state_t           state_n;
   logic [CNT_W-1:0] count;
   logic [WIDTH-1:0] shift_a;
   logic [WIDTH-1:0] shift_b;
   logic [WIDTH-1:0] sum_q;
   logic             carry;
   logic             cout_q;
   logic             bit_s;
   logic             bit_co;
   logic             accept;

   assign accept    = in_valid && (state == IDLE);
   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign busy      = (state != IDLE);
   assign sum       = sum_q;
   assign cout      = cout_q;
   assign state_dbg = state;

   full_add_cell u_cell (
      .a  (shift_a[0]),
      .b  (shift_b[0]),
      .ci (carry),
      .s  (bit_s),
      .co (bit_co)
   );

   // State register; reset aborts any operation in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   // Next-state decode: accept in IDLE, WIDTH bit-steps in RUN, wait for the consumer in DONE.
   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (in_valid)      state_n = RUN;
         RUN:     if (count == LAST) state_n = DONE;
         DONE:    if (out_ready)     state_n = IDLE;
         default:                    state_n = IDLE;
      endcase
   end

   // Datapath: load operands on accept, then one adder step per RUN cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shift_a <= '0;
         shift_b <= '0;
         sum_q   <= '0;
         carry   <= 1'b0;
         cout_q  <= 1'b0;
         count   <= '0;
      end else if (accept) begin
         shift_a <= op_a;
         shift_b <= op_b;
         carry   <= cin;
         count   <= '0;
      end else if (state == RUN) begin
         sum_q   <= {bit_s, sum_q[WIDTH-1:1]};
         shift_a <= {1'b0, shift_a[WIDTH-1:1]};
         shift_b <= {1'b0, shift_b[WIDTH-1:1]};
         carry   <= bit_co;
         count   <= count + 1'b1;
         if (count == LAST) begin
            cout_q <= bit_co;
         end
      end
   end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl: directed corner cases plus randomized operands,
// checked against a plain-arithmetic reference ({cout,sum} = a + b + cin).
module tb_serial_add_ctrl;

   localparam int W = 8;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   // WIDTH=8 instance
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] op_a;
   logic [W-1:0] op_b;
   logic         cin;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] sum;
   logic         cout;
   logic         busy;
   logic [1:0]   state_dbg;

   // WIDTH=2 instance
   logic         in_valid2;
   logic         in_ready2;
   logic [1:0]   op_a2;
   logic [1:0]   op_b2;
   logic         cin2;
   logic         out_valid2;
   logic         out_ready2;
   logic [1:0]   sum2;
   logic         cout2;
   logic         busy2;
   logic [1:0]   state_dbg2;

   serial_add_ctrl #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .op_a(op_a), .op_b(op_b), .cin(cin), .out_valid(out_valid),
      .out_ready(out_ready), .sum(sum), .cout(cout), .busy(busy),
      .state_dbg(state_dbg)
   );

   serial_add_ctrl #(.WIDTH(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
      .op_a(op_a2), .op_b(op_b2), .cin(cin2), .out_valid(out_valid2),
      .out_ready(out_ready2), .sum(sum2), .cout(cout2), .busy(busy2),
      .state_dbg(state_dbg2)
   );

   // ---------------- scoreboard ----------------
   logic [W:0] exp_q[$];
   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   // Reference model: plain (W+1)-bit addition.
   function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
      return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
   endfunction

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one operand bundle and complete the accept edge.
   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
      int n = 0;
      while (!in_ready && n < 100) begin
         tick();
         n++;
      end
      check("in_ready_before_send", in_ready, 1);
      in_valid = 1'b1;
      op_a = a;
      op_b = b;
      cin  = c;
      exp_q.push_back(ref_add(a, b, c));
      tick();
      in_valid = 1'b0;
      op_a = W'($urandom);
      op_b = W'($urandom);
      cin  = 1'($urandom);
   endtask

   // Wait for the result (called right after send), optionally stall the
   // consumer for 'hold' cycles while poking in_valid, then take it.
   task automatic collect(input int hold, input bit poke, input bit chk_lat);
      int n = 0;
      logic [W:0] e;
      while (!out_valid && n < 100) begin
         tick();
         n++;
      end
      check("out_valid_seen", out_valid, 1);
      if (chk_lat) check("latency", n, W);
      check("busy_in_done", busy, 1);
      check("in_ready_in_done", in_ready, 0);
      e = exp_q.pop_front();
      for (int i = 0; i < hold; i++) begin
         if (poke) begin
            in_valid = 1'b1;
            op_a = W'($urandom);
            op_b = W'($urandom);
            cin  = 1'($urandom);
         end
         tick();
         check("held_valid", out_valid, 1);
         check("held_in_ready", in_ready, 0);
         check("held_result", {cout, sum}, e);
      end
      in_valid = 1'b0;
      check("result", {cout, sum}, e);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("out_valid_drop", out_valid, 0);
      check("back_to_idle", in_ready, 1);
      check("result_kept_idle", {cout, sum}, e);
   endtask

   // ---------------- stimulus ----------------
   logic [W-1:0] sa[3];
   logic [W-1:0] sb[3];
   int acc_t[$];
   int sent;
   int got;
   int cyc;
   logic [W:0] e;
   int n;

   initial begin
      in_valid = 0; op_a = 0; op_b = 0; cin = 0; out_ready = 0;
      in_valid2 = 0; op_a2 = 0; op_b2 = 0; cin2 = 0; out_ready2 = 0;
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      tick();
      tick();
      // reset state
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_sum", sum, 0);
      check("rst_cout", cout, 0);
      check("rst_state", state_dbg, 2'b00);
      rst_n = 1'b1;
      tick();

      // directed cases, exact latency
      send(8'h5A, 8'h35, 1'b0); collect(0, 0, 1);
      check("5a_plus_35", {cout, sum}, 9'h08F);
      send(8'hFF, 8'h01, 1'b0); collect(0, 0, 1);
      check("ff_plus_01", {cout, sum}, 9'h100);
      send(8'hFF, 8'hFF, 1'b1); collect(0, 0, 1);
      check("ff_plus_ff_c", {cout, sum}, 9'h1FF);
      send(8'h00, 8'h00, 1'b0); collect(0, 0, 1);

      // consumer stall with ignored new operands
      send(8'h3C, 8'hA7, 1'b1); collect(5, 1, 1);
      tick();
      check("no_spurious_accept", busy, 0);
      check("queue_empty", exp_q.size(), 0);

      // randomized operands and consumer delay
      for (int k = 0; k < 20; k++) begin
         send(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
         collect($urandom_range(0, 3), 1'($urandom_range(0, 1)), 1);
      end

      // back-to-back with in_valid and out_ready held high
      for (int k = 0; k < 3; k++) begin
         sa[k] = W'($urandom);
         sb[k] = W'($urandom);
      end
      sent = 0; got = 0; cyc = 0;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      while (got < 3 && cyc < 200) begin
         if (out_valid) begin
            e = exp_q.pop_front();
            check("stream_result", {cout, sum}, e);
            got++;
         end
         if (sent == 3) in_valid = 1'b0;
         if (in_ready && in_valid) begin
            op_a = sa[sent];
            op_b = sb[sent];
            cin  = 1'b0;
            exp_q.push_back(ref_add(sa[sent], sb[sent], 1'b0));
            acc_t.push_back(cyc);
            sent++;
         end
         tick();
         cyc++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      check("stream_count", got, 3);
      if (acc_t.size() == 3) begin
         check("spacing_01", acc_t[1] - acc_t[0], W + 2);
         check("spacing_12", acc_t[2] - acc_t[1], W + 2);
      end else begin
         check("stream_accepts", acc_t.size(), 3);
      end

      // reset in the middle of RUN
      send(8'hAB, 8'h11, 1'b0);
      void'(exp_q.pop_back());
      repeat (4) tick();
      check("mid_busy_before", busy, 1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_busy", busy, 0);
      check("mid_rst_out_valid", out_valid, 0);
      check("mid_rst_sum", sum, 0);
      check("mid_rst_cout", cout, 0);
      check("mid_rst_in_ready", in_ready, 1);
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < W + 2; i++) begin
         tick();
         check("no_pulse_after_abort", out_valid, 0);
      end
      send(8'h01, 8'h01, 1'b0); collect(0, 0, 1);
      check("one_plus_one", {cout, sum}, 9'h002);

      // WIDTH=2 instance
      in_valid2 = 1'b1; op_a2 = 2'b11; op_b2 = 2'b01; cin2 = 1'b0;
      tick();
      in_valid2 = 1'b0;
      n = 0;
      while (!out_valid2 && n < 20) begin
         tick();
         n++;
      end
      check("w2_latency", n, 2);
      check("w2_sum", sum2, 2'b00);
      check("w2_cout", cout2, 1);
      out_ready2 = 1'b1;
      tick();
      out_ready2 = 1'b0;
      check("w2_idle", in_ready2, 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   // Global watchdog so the run always terminates.
   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule
